// File: rtl/mini_alu_stack_core_pkg.sv
// Shared opcode definitions for the mini ALU stack core and its users.
package mini_alu_stack_core_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_WIDTH-1:0] OP_STO  = 4'h3;
    localparam logic [OP_WIDTH-1:0] OP_BLE  = 4'h4;
    localparam logic [OP_WIDTH-1:0] OP_JMP  = 4'h5;
    localparam logic [OP_WIDTH-1:0] OP_CALL = 4'h6;
    localparam logic [OP_WIDTH-1:0] OP_RET  = 4'h7;
    localparam logic [OP_WIDTH-1:0] OP_LED  = 4'h8;
    localparam logic [OP_WIDTH-1:0] OP_HALT = 4'h9;

endpackage

// File: rtl/call_stack_lifo.sv
// Hardware return-address stack; push and pop are never requested together.
module call_stack_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int LEVEL_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iPush,
    input  logic               iPop,
    input  logic [WIDTH-1:0]   iData,
    output logic [WIDTH-1:0]   oTop,
    output logic [LEVEL_W-1:0] oLevel,
    output logic               oFull,
    output logic               oEmpty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LEVEL_W-1:0] level;

    assign oLevel = level;
    assign oFull  = (level == LEVEL_W'(DEPTH));
    assign oEmpty = (level == '0);
    assign oTop   = mem[IDX_W'(level - LEVEL_W'(1))];

    // NOTE: entries need no reset; only the occupancy count decides which are valid.
    always_ff @(posedge Clock) begin
        if (iPush && !oFull) mem[IDX_W'(level)] <= iData;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            level <= '0;
        end else if (iPush && !oFull) begin
            level <= level + LEVEL_W'(1);
        end else if (iPop && !oEmpty) begin
            level <= level - LEVEL_W'(1);
        end
    end

endmodule

// File: rtl/mini_alu_stack_core.sv
// Two-stage fetch/execute mini ALU core with one-deep forwarding, return stack,
// LED channels and a HALT state.
module mini_alu_stack_core
    import mini_alu_stack_core_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int IP_WIDTH    = 16,
    parameter int STACK_DEPTH = 4,
    parameter int LED_CH      = 2
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic [OP_WIDTH+3*ADDR_WIDTH-1:0]     iInstruction,
    output logic [IP_WIDTH-1:0]                  oIP,
    output logic [8*LED_CH-1:0]                  oLed,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     oStackLevel,
    output logic                                 oStackErr,
    output logic                                 oHalted
);

    logic [OP_WIDTH+3*ADDR_WIDTH-1:0] instr;
    logic [IP_WIDTH-1:0]              pc;
    logic [OP_WIDTH-1:0]              op;
    logic [ADDR_WIDTH-1:0]            dst, src1, src0;
    logic [ADDR_WIDTH-1:0]            fetchSrc1, fetchSrc0;

    assign {op, dst, src1, src0} = instr;
    assign fetchSrc1 = iInstruction[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign fetchSrc0 = iInstruction[ADDR_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] regMem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdData0, rdData1, srcVal0, srcVal1;
    logic                  fwdValid;
    logic [ADDR_WIDTH-1:0] fwdAddr;
    logic [DATA_WIDTH-1:0] fwdData;

    logic                  taken, wrEn, ledWr, haltNow, push, pop, errSet;
    logic [IP_WIDTH-1:0]   target;
    logic [DATA_WIDTH-1:0] wrData;
    logic [IP_WIDTH-1:0]   stackTop;
    logic                  stackFull, stackEmpty;

    call_stack_lifo #(
        .WIDTH(IP_WIDTH),
        .DEPTH(STACK_DEPTH)
    ) uStack (
        .Clock (Clock),
        .Reset (Reset),
        .iPush (push),
        .iPop  (pop),
        .iData (pc),
        .oTop  (stackTop),
        .oLevel(oStackLevel),
        .oFull (stackFull),
        .oEmpty(stackEmpty)
    );

    // The regfile read for this instruction raced the previous result's write.
    assign srcVal0 = (fwdValid && fwdAddr == src0) ? fwdData : rdData0;
    assign srcVal1 = (fwdValid && fwdAddr == src1) ? fwdData : rdData1;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        taken   = 1'b0;
        target  = IP_WIDTH'(dst);
        wrEn    = 1'b0;
        wrData  = '0;
        ledWr   = 1'b0;
        haltNow = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        errSet  = 1'b0;
        case (op)
            OP_ADD: begin wrEn = 1'b1; wrData = srcVal1 + srcVal0; end
            OP_SUB: begin wrEn = 1'b1; wrData = srcVal1 - srcVal0; end
            OP_STO: begin wrEn = 1'b1; wrData = DATA_WIDTH'({src1, src0}); end
            OP_BLE: taken = (srcVal1 <= srcVal0);
            OP_JMP: taken = 1'b1;
            OP_CALL: begin
                push   = !stackFull;
                taken  = !stackFull;
                errSet = stackFull;
            end
            OP_RET: begin
                pop    = !stackEmpty;
                taken  = !stackEmpty;
                target = stackTop;
                errSet = stackEmpty;
            end
            OP_LED:  ledWr = 1'b1;
            OP_HALT: haltNow = 1'b1;
            default: ;
        endcase
    end

    assign oIP = taken ? target : pc;

    // NOTE: the register file is left out of reset; its contents survive Reset.
    always_ff @(posedge Clock) begin
        if (wrEn && Reset) regMem[dst] <= wrData;
        rdData0 <= regMem[fetchSrc0];
        rdData1 <= regMem[fetchSrc1];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc        <= '0;
            instr     <= '0;
            oHalted   <= 1'b0;
            oStackErr <= 1'b0;
            oLed      <= '0;
            fwdValid  <= 1'b0;
            fwdAddr   <= '0;
            fwdData   <= '0;
        end else begin
            if (oHalted || haltNow) begin
                oHalted <= 1'b1;
                instr   <= '0;
            end else begin
                pc    <= oIP + IP_WIDTH'(1);
                instr <= iInstruction;
            end
            fwdValid <= wrEn;
            fwdAddr  <= dst;
            fwdData  <= wrData;
            if (errSet) oStackErr <= 1'b1;
            for (int k = 0; k < LED_CH; k++) begin
                if (ledWr && dst == ADDR_WIDTH'(k)) oLed[8*k +: 8] <= srcVal1[7:0];
            end
        end
    end

endmodule
